// File: rtl/bet_pkg.sv
// Shared encodings for the Indian Poker bet turn sequencer: FSM states,
// turn owner values and bit positions of the button vector.
package bet_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_TURN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic TURN_P1 = 1'b0;
  localparam logic TURN_P2 = 1'b1;

  localparam int NUM_BTN      = 7;
  localparam int BTN_P1_UP    = 0;
  localparam int BTN_P1_DOWN  = 1;
  localparam int BTN_P1_DONE  = 2;
  localparam int BTN_P2_UP    = 3;
  localparam int BTN_P2_DOWN  = 4;
  localparam int BTN_P2_DONE  = 5;
  localparam int BTN_START    = 6;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector over a vector of level inputs; the history register
// tracks the live inputs even in reset so held buttons never fire on release.
module edge_det #(
  parameter int WIDTH = 7
) (
  input  logic             i_clk,
  input  logic             i_rstN,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_prev <= i_in;
    end else begin
      r_prev <= i_in;
    end
  end

  assign o_edge = i_in & ~r_prev;

endmodule

// File: rtl/bet_turn_ctrl.sv
// Turn-based sequencer for the shared up/down bet counter: grants the counter
// to one player at a time and turns button edges into single-cycle pulses.
module bet_turn_ctrl
  import bet_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int MAX_BET      = 8,
  parameter int MIN_BET      = 0,
  parameter int FIRST_PLAYER = 0
) (
  input  logic             i_clk,
  input  logic             i_clrN,
  input  logic             i_start,
  input  logic             i_p1Up,
  input  logic             i_p1Down,
  input  logic             i_p1Done,
  input  logic             i_p2Up,
  input  logic             i_p2Down,
  input  logic             i_p2Done,
  input  logic [WIDTH-1:0] i_cntQ,
  output logic             o_cntUp,
  output logic             o_cntDown,
  output logic             o_cntEn,
  output logic             o_cntL,
  output logic             o_cntClr,
  output logic [WIDTH-1:0] o_cntMax,
  output logic [WIDTH-1:0] o_cntMin,
  output logic             o_turn,
  output logic             o_busy,
  output logic             o_roundEnd
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MAX_BET);
  localparam logic [WIDTH-1:0] MIN_V   = WIDTH'(MIN_BET);
  localparam logic             FIRST_V = 1'(FIRST_PLAYER);

  state_t             r_state;
  logic [WIDTH-1:0]   r_base;
  logic               r_moved;
  logic               r_turn;
  logic               r_cntUp;
  logic               r_cntDown;
  logic               r_cntEn;
  logic               r_cntL;
  logic               r_cntClr;
  logic               r_busy;
  logic               r_roundEnd;

  logic [NUM_BTN-1:0] w_btn;
  logic [NUM_BTN-1:0] w_edge;
  logic               w_up;
  logic               w_down;
  logic               w_done;

  assign w_btn[BTN_P1_UP]   = i_p1Up;
  assign w_btn[BTN_P1_DOWN] = i_p1Down;
  assign w_btn[BTN_P1_DONE] = i_p1Done;
  assign w_btn[BTN_P2_UP]   = i_p2Up;
  assign w_btn[BTN_P2_DOWN] = i_p2Down;
  assign w_btn[BTN_P2_DONE] = i_p2Done;
  assign w_btn[BTN_START]   = i_start;

  edge_det #(.WIDTH(NUM_BTN)) u_edgeDet (
    .i_clk  (i_clk),
    .i_rstN (i_clrN),
    .i_in   (w_btn),
    .o_edge (w_edge)
  );

  // Only the player holding the turn can reach the counter.
  assign w_up   = (r_turn == TURN_P2) ? w_edge[BTN_P2_UP]   : w_edge[BTN_P1_UP];
  assign w_down = (r_turn == TURN_P2) ? w_edge[BTN_P2_DOWN] : w_edge[BTN_P1_DOWN];
  assign w_done = (r_turn == TURN_P2) ? w_edge[BTN_P2_DONE] : w_edge[BTN_P1_DONE];

  always_ff @(posedge i_clk) begin
    if (!i_clrN) begin
      r_state    <= S_IDLE;
      r_base     <= MIN_V;
      r_moved    <= 1'b0;
      r_turn     <= FIRST_V;
      r_cntUp    <= 1'b0;
      r_cntDown  <= 1'b0;
      r_cntEn    <= 1'b0;
      r_cntL     <= 1'b0;
      r_cntClr   <= 1'b1;
      r_busy     <= 1'b0;
      r_roundEnd <= 1'b0;
    end else begin
      r_cntUp   <= 1'b0;
      r_cntDown <= 1'b0;
      r_cntL    <= 1'b0;
      // Busy spans the pulse cycle and the counter's update cycle after it.
      r_busy    <= r_cntUp | r_cntDown;
      case (r_state)
        S_IDLE: begin
          r_cntClr   <= 1'b1;
          r_cntEn    <= 1'b0;
          r_roundEnd <= 1'b0;
          if (w_edge[BTN_START]) begin
            r_state  <= S_LOAD;
            r_cntL   <= 1'b1;
            r_cntEn  <= 1'b1;
            r_cntClr <= 1'b0;
          end
        end
        S_LOAD: begin
          r_base  <= MIN_V;
          r_moved <= 1'b0;
          r_turn  <= FIRST_V;
          r_cntEn <= 1'b1;
          r_state <= S_TURN;
        end
        S_TURN: begin
          r_cntEn <= 1'b1;
          if (!r_busy) begin
            if (w_up && w_down) begin
              r_busy <= 1'b0;
            end else if (w_up) begin
              if (i_cntQ < MAX_V) begin
                r_cntUp <= 1'b1;
                r_busy  <= 1'b1;
              end
            end else if (w_down) begin
              if (i_cntQ > r_base) begin
                r_cntDown <= 1'b1;
                r_busy    <= 1'b1;
              end
            end else if (w_done) begin
              if ((i_cntQ == MAX_V) || (r_moved && (i_cntQ == r_base))) begin
                r_state    <= S_DONE;
                r_roundEnd <= 1'b1;
                r_cntEn    <= 1'b0;
              end else begin
                r_turn  <= ~r_turn;
                r_base  <= i_cntQ;
                r_moved <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_roundEnd <= 1'b1;
          r_cntEn    <= 1'b0;
          if (w_edge[BTN_START]) begin
            r_state    <= S_LOAD;
            r_cntL     <= 1'b1;
            r_cntEn    <= 1'b1;
            r_roundEnd <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cntUp    = r_cntUp;
  assign o_cntDown  = r_cntDown;
  assign o_cntEn    = r_cntEn;
  assign o_cntL     = r_cntL;
  assign o_cntClr   = r_cntClr;
  assign o_cntMax   = MAX_V;
  assign o_cntMin   = MIN_V;
  assign o_turn     = r_turn;
  assign o_busy     = r_busy;
  assign o_roundEnd = r_roundEnd;

endmodule

// File: tb/tb_bet_turn_ctrl.sv
// Directed bench for bet_turn_ctrl with a behavioural bet counter driven by
// the DUT's pulses; every check is an immediate assertion.
module tb_bet_turn_ctrl;

  localparam logic [6:0] P1_UP   = 7'b0000001;
  localparam logic [6:0] P1_DOWN = 7'b0000010;
  localparam logic [6:0] P1_DONE = 7'b0000100;
  localparam logic [6:0] P2_UP   = 7'b0001000;
  localparam logic [6:0] P2_DOWN = 7'b0010000;
  localparam logic [6:0] P2_DONE = 7'b0100000;
  localparam logic [6:0] START   = 7'b1000000;
  localparam logic [6:0] NONE    = 7'b0000000;

  logic       clk = 1'b0;
  logic       clrN = 1'b0;
  logic [6:0] btn = 7'b0;
  logic [7:0] modelQ = 8'd0;

  logic       cntUp, cntDown, cntEn, cntL, cntClr, turn, busy, roundEnd;
  logic [7:0] cntMax, cntMin;

  int nAsserts = 0;
  int nFails   = 0;

  bet_turn_ctrl dut (
    .i_clk      (clk),
    .i_clrN     (clrN),
    .i_start    (btn[6]),
    .i_p1Up     (btn[0]),
    .i_p1Down   (btn[1]),
    .i_p1Done   (btn[2]),
    .i_p2Up     (btn[3]),
    .i_p2Down   (btn[4]),
    .i_p2Done   (btn[5]),
    .i_cntQ     (modelQ),
    .o_cntUp    (cntUp),
    .o_cntDown  (cntDown),
    .o_cntEn    (cntEn),
    .o_cntL     (cntL),
    .o_cntClr   (cntClr),
    .o_cntMax   (cntMax),
    .o_cntMin   (cntMin),
    .o_turn     (turn),
    .o_busy     (busy),
    .o_roundEnd (roundEnd)
  );

  always #5 clk = ~clk;

  // Stand-in for the Updown_design counter: clear wins, then load, then step.
  always @(posedge clk) begin
    if (cntClr) modelQ <= 8'd0;
    else if (cntEn && cntL) modelQ <= cntMin;
    else if (cntEn && cntUp) modelQ <= modelQ + 8'd1;
    else if (cntEn && cntDown) modelQ <= modelQ - 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] b);
    btn = b;
    tick();
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One button press on a 4-cycle slot: pulse cycle, counter update cycle, idle.
  task automatic pressStep(input string tag, input logic [6:0] b,
                           input logic expUp, input logic expDown);
    applyStimulus(b);
    checkBit({tag, "_up"}, cntUp, expUp);
    checkBit({tag, "_down"}, cntDown, expDown);
    checkBit({tag, "_busy1"}, busy, expUp | expDown);
    applyStimulus(NONE);
    checkBit({tag, "_pulse_end"}, cntUp | cntDown, 1'b0);
    checkBit({tag, "_busy2"}, busy, expUp | expDown);
    applyStimulus(NONE);
    checkBit({tag, "_busy_off"}, busy, 1'b0);
    applyStimulus(NONE);
  endtask

  initial begin
    $display("[TB] reset and round start");
    clrN = 1'b0;
    applyStimulus(NONE);
    applyStimulus(NONE);
    checkBit("rst_clr", cntClr, 1'b1);
    checkBit("rst_turn", turn, 1'b0);
    checkBit("rst_en", cntEn, 1'b0);
    checkBit("rst_load", cntL, 1'b0);
    checkBit("rst_up", cntUp, 1'b0);
    checkBit("rst_down", cntDown, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_end", roundEnd, 1'b0);
    checkOutput("cnt_max", cntMax, 8'd8);
    checkOutput("cnt_min", cntMin, 8'd0);
    clrN = 1'b1;
    applyStimulus(NONE);
    checkBit("idle_clr", cntClr, 1'b1);
    applyStimulus(START);
    checkBit("load_pulse", cntL, 1'b1);
    checkBit("load_en", cntEn, 1'b1);
    checkBit("load_clr", cntClr, 1'b0);
    applyStimulus(NONE);
    checkBit("load_once", cntL, 1'b0);
    checkBit("turn_en", cntEn, 1'b1);
    checkBit("turn_p1", turn, 1'b0);

    $display("[TB] P1 raises three times");
    for (int i = 0; i < 3; i++) pressStep("p1_up", P1_UP, 1'b1, 1'b0);
    checkOutput("q_after_3up", modelQ, 8'd3);
    pressStep("p2_up_offturn", P2_UP, 1'b0, 1'b0);
    checkOutput("q_offturn", modelQ, 8'd3);

    $display("[TB] P2 turn and call");
    applyStimulus(P1_DONE);
    checkBit("turn_p2", turn, 1'b1);
    checkBit("no_end_pass", roundEnd, 1'b0);
    applyStimulus(NONE);
    pressStep("p2_down_floor", P2_DOWN, 1'b0, 1'b0);
    pressStep("p2_up", P2_UP, 1'b1, 1'b0);
    checkOutput("q_p2_up", modelQ, 8'd4);
    pressStep("p2_down", P2_DOWN, 1'b0, 1'b1);
    checkOutput("q_p2_down", modelQ, 8'd3);
    applyStimulus(P2_DONE);
    checkBit("call_end", roundEnd, 1'b1);
    checkBit("call_en", cntEn, 1'b0);
    applyStimulus(NONE);
    pressStep("done_ignores_up", P2_UP, 1'b0, 1'b0);
    checkBit("done_hold", roundEnd, 1'b1);

    $display("[TB] all-in round");
    applyStimulus(START);
    checkBit("r2_load", cntL, 1'b1);
    checkBit("r2_end_clr", roundEnd, 1'b0);
    applyStimulus(NONE);
    checkBit("r2_turn_p1", turn, 1'b0);
    checkOutput("r2_q_loaded", modelQ, 8'd0);
    for (int i = 0; i < 8; i++) pressStep("r2_up", P1_UP, 1'b1, 1'b0);
    checkOutput("q_max", modelQ, 8'd8);
    pressStep("up_at_max", P1_UP, 1'b0, 1'b0);
    checkOutput("q_still_max", modelQ, 8'd8);
    applyStimulus(P1_DONE);
    checkBit("allin_end", roundEnd, 1'b1);
    applyStimulus(NONE);

    $display("[TB] busy window and conflicting edges");
    applyStimulus(START);
    applyStimulus(NONE);
    applyStimulus(P1_UP);
    checkBit("bw_up", cntUp, 1'b1);
    checkBit("bw_busy1", busy, 1'b1);
    applyStimulus(P1_DOWN);
    checkBit("bw_up_end", cntUp, 1'b0);
    checkBit("bw_down_drop", cntDown, 1'b0);
    checkBit("bw_busy2", busy, 1'b1);
    applyStimulus(NONE);
    checkBit("bw_busy_off", busy, 1'b0);
    checkBit("bw_no_down", cntDown, 1'b0);
    applyStimulus(NONE);
    checkOutput("bw_q", modelQ, 8'd1);
    applyStimulus(P1_UP | P1_DOWN);
    checkBit("both_up", cntUp, 1'b0);
    checkBit("both_down", cntDown, 1'b0);
    checkBit("both_busy", busy, 1'b0);
    applyStimulus(NONE);
    checkOutput("both_q", modelQ, 8'd1);
    pressStep("up_with_done", P1_UP | P1_DONE, 1'b1, 1'b0);
    checkBit("up_with_done_turn", turn, 1'b0);
    checkOutput("up_with_done_q", modelQ, 8'd2);

    $display("[TB] reset mid-turn with P1_UP held");
    clrN = 1'b0;
    applyStimulus(P1_UP);
    checkBit("mid_rst_up", cntUp, 1'b0);
    checkBit("mid_rst_clr", cntClr, 1'b1);
    checkBit("mid_rst_en", cntEn, 1'b0);
    clrN = 1'b1;
    applyStimulus(P1_UP);
    checkBit("rel_held_up", cntUp, 1'b0);
    checkOutput("rel_q", modelQ, 8'd0);
    applyStimulus(START | P1_UP);
    checkBit("rel_load", cntL, 1'b1);
    applyStimulus(P1_UP);
    applyStimulus(P1_UP);
    checkBit("held_no_up", cntUp, 1'b0);
    checkBit("held_no_busy", busy, 1'b0);
    applyStimulus(NONE);
    pressStep("fresh_up", P1_UP, 1'b1, 1'b0);
    checkOutput("fresh_q", modelQ, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
